// File: rtl/instruction_decode.sv
// instruction_decode: ID stage of a five-stage MIPS pipeline.
//   Holds the 32x32 register file (write-through bypass from write-back),
//   the main control decoder, the sign extender and the load-use hazard
//   detector. Fills the ID/EX pipeline register.
// Ports:
//   clk, reset                  clock, async active-high reset
//   instruction_if_id, pc_plus4_if_id   IF/ID contents
//   wb_reg_write, wb_write_register, wb_write_data   write-back port
//   flush                       branch taken in MEM, kill ID instruction
//   stall                       combinational, hold PC and IF/ID
//   *_id_ex                     ID/EX register outputs
module instruction_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_if_id,
    input  logic [31:0] pc_plus4_if_id,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_register,
    input  logic [31:0] wb_write_data,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] read_data_1_id_ex,
    output logic [31:0] read_data_2_id_ex,
    output logic [31:0] extended_branch_offset_id_ex,
    output logic [31:0] supposed_next_address_id_ex,
    output logic [4:0]  next_instruction_20_16_id_ex,
    output logic [4:0]  next_instruction_15_11_id_ex,
    output logic [1:0]  ctrl_aluOp_id_ex,
    output logic        ctrl_aluSrc_id_ex,
    output logic        ctrl_regDest_id_ex,
    output logic        ctrl_branch_id_ex,
    output logic        ctrl_memRead_id_ex,
    output logic        ctrl_memWrite_id_ex,
    output logic        ctrl_regWrite_id_ex,
    output logic        ctrl_memToReg_id_ex
);

    typedef struct packed {
        logic       reg_dest;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt;
    logic [31:0] regs [32];
    logic [31:0] rs_data, rt_data, ext;
    ctrl_t       ctrl;
    logic        bubble;

    assign opcode = instruction_if_id[31:26];
    assign rs     = instruction_if_id[25:21];
    assign rt     = instruction_if_id[20:16];
    assign ext    = {{16{instruction_if_id[15]}}, instruction_if_id[15:0]};

    // Main control decoder; unknown opcodes become NOPs.
    always_comb begin
        ctrl = '0;
        case (opcode)
            6'b000000: ctrl = 9'b1_0_0_1_0_0_0_10;  // R-type
            6'b100011: ctrl = 9'b0_1_1_1_1_0_0_00;  // lw
            6'b101011: ctrl = 9'b0_1_0_0_0_1_0_00;  // sw
            6'b000100: ctrl = 9'b0_0_0_0_0_0_1_01;  // beq
            6'b001000: ctrl = 9'b0_1_0_1_0_0_0_00;  // addi
            default:   ctrl = '0;
        endcase
    end

    // Reads with write-through bypass so a same-cycle write-back is seen.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs != 5'd0)
            rs_data = (wb_reg_write && wb_write_register == rs) ? wb_write_data : regs[rs];
        if (rt != 5'd0)
            rt_data = (wb_reg_write && wb_write_register == rt) ? wb_write_data : regs[rt];
    end

    // Load-use: the load now in EX writes a register this instruction reads.
    // A flush kills the instruction anyway, so it never stalls.
    assign stall = ctrl_memRead_id_ex
                 && (next_instruction_20_16_id_ex != 5'd0)
                 && (next_instruction_20_16_id_ex == rs || next_instruction_20_16_id_ex == rt)
                 && !flush;

    assign bubble = flush || stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_reg_write && wb_write_register != 5'd0) begin
            regs[wb_write_register] <= wb_write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || bubble) begin
            read_data_1_id_ex            <= '0;
            read_data_2_id_ex            <= '0;
            extended_branch_offset_id_ex <= '0;
            supposed_next_address_id_ex  <= '0;
            next_instruction_20_16_id_ex <= '0;
            next_instruction_15_11_id_ex <= '0;
            ctrl_aluOp_id_ex             <= '0;
            ctrl_aluSrc_id_ex            <= 1'b0;
            ctrl_regDest_id_ex           <= 1'b0;
            ctrl_branch_id_ex            <= 1'b0;
            ctrl_memRead_id_ex           <= 1'b0;
            ctrl_memWrite_id_ex          <= 1'b0;
            ctrl_regWrite_id_ex          <= 1'b0;
            ctrl_memToReg_id_ex          <= 1'b0;
        end else begin
            read_data_1_id_ex            <= rs_data;
            read_data_2_id_ex            <= rt_data;
            extended_branch_offset_id_ex <= ext;
            supposed_next_address_id_ex  <= pc_plus4_if_id;
            next_instruction_20_16_id_ex <= rt;
            next_instruction_15_11_id_ex <= instruction_if_id[15:11];
            ctrl_aluOp_id_ex             <= ctrl.alu_op;
            ctrl_aluSrc_id_ex            <= ctrl.alu_src;
            ctrl_regDest_id_ex           <= ctrl.reg_dest;
            ctrl_branch_id_ex            <= ctrl.branch;
            ctrl_memRead_id_ex           <= ctrl.mem_read;
            ctrl_memWrite_id_ex          <= ctrl.mem_write;
            ctrl_regWrite_id_ex          <= ctrl.reg_write;
            ctrl_memToReg_id_ex          <= ctrl.mem_to_reg;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: scoreboard bench for instruction_decode.
//   A driver issues one instruction per cycle and pushes the expected ID/EX
//   contents computed by a reference model; a monitor pops and compares
//   after every rising edge.
module tb_instruction_decode;

    typedef struct packed {
        logic [31:0] rd1, rd2, off, pc;
        logic [4:0]  rt, rd;
        logic [1:0]  aluop;
        logic alusrc, regdest, branch, memread, memwrite, regwrite, memtoreg;
    } idex_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc4, wbd;
    logic        wbe, flush;
    logic [4:0]  wbr;
    logic        stall;
    logic [31:0] rd1, rd2, off, nxt;
    logic [4:0]  f_rt, f_rd;
    logic [1:0]  aluop;
    logic        alusrc, regdest, branch, memread, memwrite, regwrite, memtoreg;

    int n_checks = 0;
    int n_err    = 0;

    idex_t       sb [$];
    idex_t       prev;
    logic [31:0] mregs [32];
    logic        last_stall;

    instruction_decode dut (
        .clk(clk), .reset(rst),
        .instruction_if_id(instr), .pc_plus4_if_id(pc4),
        .wb_reg_write(wbe), .wb_write_register(wbr), .wb_write_data(wbd),
        .flush(flush), .stall(stall),
        .read_data_1_id_ex(rd1), .read_data_2_id_ex(rd2),
        .extended_branch_offset_id_ex(off), .supposed_next_address_id_ex(nxt),
        .next_instruction_20_16_id_ex(f_rt), .next_instruction_15_11_id_ex(f_rd),
        .ctrl_aluOp_id_ex(aluop), .ctrl_aluSrc_id_ex(alusrc),
        .ctrl_regDest_id_ex(regdest), .ctrl_branch_id_ex(branch),
        .ctrl_memRead_id_ex(memread), .ctrl_memWrite_id_ex(memwrite),
        .ctrl_regWrite_id_ex(regwrite), .ctrl_memToReg_id_ex(memtoreg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic idex_t actual();
        return '{rd1: rd1, rd2: rd2, off: off, pc: nxt, rt: f_rt, rd: f_rd, aluop: aluop,
                 alusrc: alusrc, regdest: regdest, branch: branch, memread: memread,
                 memwrite: memwrite, regwrite: regwrite, memtoreg: memtoreg};
    endfunction

    // Register value as seen by decode this cycle (array plus bypass).
    function automatic logic [31:0] rdreg(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wbe && wbr == r) return wbd;
        return mregs[r];
    endfunction

    // Reference model for one cycle, using the currently driven inputs.
    task automatic model_cycle();
        idex_t       e;
        logic [8:0]  c;   // regDest aluSrc memToReg regWrite memRead memWrite branch aluOp
        logic [4:0]  rs, rt;
        logic        es;
        rs = instr[25:21];
        rt = instr[20:16];
        es = prev.memread && prev.rt != 0 && (prev.rt == rs || prev.rt == rt) && !flush;
        chk("stall", 160'(stall), 160'(es));
        e = '0;
        if (!(flush || es)) begin
            case (instr[31:26])
                6'd0:  c = 9'b100100010;
                6'h23: c = 9'b011110000;
                6'h2b: c = 9'b010001000;
                6'h04: c = 9'b000000101;
                6'h08: c = 9'b010100000;
                default: c = 9'b0;
            endcase
            e.rd1 = rdreg(rs);
            e.rd2 = rdreg(rt);
            e.off = 32'($signed(instr[15:0]));
            e.pc  = pc4;
            e.rt  = rt;
            e.rd  = instr[15:11];
            e.regdest  = c[8];
            e.alusrc   = c[7];
            e.memtoreg = c[6];
            e.regwrite = c[5];
            e.memread  = c[4];
            e.memwrite = c[3];
            e.branch   = c[2];
            e.aluop    = c[1:0];
        end
        sb.push_back(e);
        prev = e;
        last_stall = es;
        if (wbe && wbr != 0) mregs[wbr] = wbd;
    endtask

    task automatic step(input logic [31:0] i, input logic [31:0] p, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd, input logic fl);
        @(negedge clk);
        instr = i; pc4 = p; wbe = we; wbr = wr; wbd = wd; flush = fl;
        #1;
        model_cycle();
    endtask

    // Async reset pulse between edges; then queue the next idle cycle.
    task automatic do_reset();
        @(negedge clk);
        instr = 32'hFC00_0000; pc4 = 0; wbe = 0; wbr = 0; wbd = 0; flush = 0;
        #1 rst = 1'b1;
        #1;
        chk("reset_idex", 160'(actual()), 160'(0));
        chk("reset_stall", 160'(stall), 160'(0));
        sb.delete();
        prev = '0;
        for (int k = 0; k < 32; k++) mregs[k] = '0;
        #1 rst = 1'b0;
        #1 model_cycle();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom % 6)
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2b;
            3: op = 6'h04;
            4: op = 6'h08;
            default: op = 6'($urandom);
        endcase
        return {op, 5'($urandom % 8), 5'($urandom % 8), 16'($urandom)};
    endfunction

    // Monitor
    initial begin
        idex_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("idex", 160'(actual()), 160'(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cur;
        rst = 1'b1; prev = '0; last_stall = 0;
        instr = 0; pc4 = 0; wbe = 0; wbr = 0; wbd = 0; flush = 0;
        repeat (2) @(posedge clk);
        do_reset();

        // R-type with preloaded operands
        step(32'hFC00_0000, 32'h0, 1, 5'd1, 32'd7, 0);
        step(32'hFC00_0000, 32'h0, 1, 5'd2, 32'd5, 0);
        step(32'h0022_1820, 32'h104, 0, 5'd0, 32'd0, 0);
        @(posedge clk); #2;
        chk("rtype_rd1", 160'(rd1), 160'(7));
        chk("rtype_rd2", 160'(rd2), 160'(5));
        chk("rtype_off", 160'(off), 160'(32'h1820));
        chk("rtype_ctl", 160'({aluop, regdest, regwrite, f_rd}), 160'({2'b10, 1'b1, 1'b1, 5'd3}));

        // Sign extension on beq
        step(32'h1000_FFFE, 32'h204, 0, 5'd0, 32'd0, 0);
        @(posedge clk); #2;
        chk("beq_off", 160'(off), 160'(32'hFFFF_FFFE));
        chk("beq_ctl", 160'({branch, aluop, nxt}), 160'({1'b1, 2'b01, 32'h204}));

        // Bypass, then bypass attempt on $0
        step(32'h2085_0001, 32'h8, 1, 5'd4, 32'hDEAD_BEEF, 0);
        @(posedge clk); #2;
        chk("bypass_r4", 160'(rd1), 160'(32'hDEAD_BEEF));
        step(32'h2005_0001, 32'hC, 1, 5'd0, 32'hDEAD_BEEF, 0);
        @(posedge clk); #2;
        chk("bypass_r0", 160'(rd1), 160'(0));

        // Load-use: lw $2,0($1); add $3,$2,$2
        step(32'h8C22_0000, 32'h10, 0, 5'd0, 32'd0, 0);
        step(32'h0042_1820, 32'h14, 0, 5'd0, 32'd0, 0);
        chk("lu_stall1", 160'(stall), 160'(1));
        @(posedge clk); #2;
        chk("lu_bubble", 160'(actual()), 160'(0));
        step(32'h0042_1820, 32'h14, 0, 5'd0, 32'd0, 0);
        chk("lu_stall0", 160'(stall), 160'(0));
        @(posedge clk); #2;
        chk("lu_add", 160'({regwrite, f_rd, nxt}), 160'({1'b1, 5'd3, 32'h14}));

        // Flush wins over a load-use hazard
        step(32'h8C22_0000, 32'h20, 0, 5'd0, 32'd0, 0);
        step(32'h0042_1820, 32'h24, 0, 5'd0, 32'd0, 1);
        chk("flush_stall", 160'(stall), 160'(0));
        @(posedge clk); #2;
        chk("flush_bubble", 160'(actual()), 160'(0));

        // Randomized stream; IF/ID holds while stalled
        cur = rand_instr();
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) cur = rand_instr();
            step(cur, $urandom, 1'($urandom), 5'($urandom % 8), $urandom,
                 ($urandom % 10) == 0);
            if (n == 200) begin
                @(posedge clk);
                do_reset();
                step(32'h20A1_0000, 32'h4, 0, 5'd0, 32'd0, 0);
                @(posedge clk); #2;
                chk("reset_r5", 160'(rd1), 160'(0));
            end
        end

        @(posedge clk); #2;
        chk("sb_drained", 160'(sb.size()), 160'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Instruction-decode stage of the five-stage MIPS pipeline: takes the IF/ID pipeline register contents and the write-back port, and fills the ID/EX pipeline register consumed by the execute stage.
- Contains the 32×32 register file with write-through bypass, the main control decoder and the sign extender.
- Contains the load-use hazard detector, which drives the stall to fetch and inserts bubbles.
- Handles flushes from taken branches.

## Interface
Parameters: none (widths fixed by the ISA).
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears register file and ID/EX register
- instruction_if_id  in  32  instruction from IF/ID
- pc_plus4_if_id  in  32  PC+4 from IF/ID
- wb_reg_write  in  1  write-back enable
- wb_write_register  in  5  write-back destination
- wb_write_data  in  32  write-back data
- flush  in  1  branch taken in MEM; kill instruction in ID
- stall  out  1  combinational; hold PC and IF/ID this cycle
- read_data_1_id_ex, read_data_2_id_ex  out  32  rs / rt operands
- extended_branch_offset_id_ex  out  32  sign-extended instruction[15:0]
- supposed_next_address_id_ex  out  32  registered pc_plus4_if_id
- next_instruction_20_16_id_ex, next_instruction_15_11_id_ex  out  5  rt, rd fields
- ctrl_aluOp_id_ex  out  2  ALU operation class
- ctrl_aluSrc_id_ex, ctrl_regDest_id_ex  out  1 each  operand / destination select
- ctrl_branch_id_ex, ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_regWrite_id_ex, ctrl_memToReg_id_ex  out  1 each  downstream control

## Operation
- **Decode.** Decode is on opcode = instruction[31:26]. Each line gives regDest/aluSrc/memToReg/regWrite/memRead/memWrite/branch, then aluOp.
  - 000000 R-type: 1/0/0/1/0/0/0, aluOp 10
  - 100011 lw: 0/1/1/1/1/0/0, aluOp 00
  - 101011 sw: 0/1/0/0/0/1/0, aluOp 00
  - 000100 beq: 0/0/0/0/0/0/1, aluOp 01
  - 001000 addi: 0/1/0/1/0/0/0, aluOp 00
  - Any other opcode: all controls 0 (treated as NOP).
- **Register file.** 32×32, written on the rising edge when wb_reg_write=1 and wb_write_register≠0. Register $0 always reads 0.
- **Bypass.** A read of rs or rt returns wb_write_data when wb_reg_write=1, wb_write_register equals the read address, and that address is nonzero. This covers write and read to the same register in the same cycle.
- **Sign extension.** extended_branch_offset = {16{instruction[15]}, instruction[15:0]}. The full 32-bit value is passed on, so execute's funct/shamt slices remain valid.
- **Load-use hazard.**
  - stall = ctrl_memRead_id_ex & (next_instruction_20_16_id_ex≠0) & (next_instruction_20_16_id_ex == instruction[25:21] or == instruction[20:16]) & ~flush.
  - The comparison is made against the rs and rt fields of the instruction in ID.
- **ID/EX update priority** (each rising edge):
  1. flush=1: load bubble.
  2. stall=1: load bubble; IF/ID is held externally, so the same instruction re-decodes next cycle.
  3. Otherwise: load the decoded instruction.
- **Bubble.** All ctrl_* outputs and all data/field outputs are 0.

## Timing
- **Reset.** Asserting reset asynchronously clears every ID/EX output and all 32 registers to 0. stall then evaluates 0. Deasserting reset has no effect until the next clk edge.
- **Latency.** The ID/EX register updates 1 cycle after an instruction is presented.
- **Write-back timing.** A register write-back is visible to a decode in the same cycle (via bypass) and to all later cycles (via the array).
- **stall duration.** stall is asserted for exactly 1 cycle per load-use pair. After the bubble, ctrl_memRead_id_ex=0, so stall drops.
- **Flush during stall.** If flush and a hazard coincide, flush wins: bubble inserted, stall=0.
- **Reset mid-stream.** Reset in the middle of a stall or flush discards the in-flight instruction. No other state persists.

## Test plan
- **Reset.** Pulse reset asynchronously between clk edges -> all outputs 0 immediately; reading $5 returns 0.
- **R-type decode.** Preload $1=7 and $2=5 via write-back, then decode 0x00221820 (add $3,$1,$2) -> next edge: read_data_1=7, read_data_2=5, aluOp=10, regDest=1, regWrite=1, field_15_11=3, offset=0x00001820.
- **Sign extension.** Decode beq with imm 0xFFFE -> offset=0xFFFFFFFE, branch=1, aluOp=01, supposed_next_address = pc_plus4_if_id.
- **Bypass.** Set wb_write_register=4, wb_write_data=0xDEADBEEF, wb_reg_write=1 while decoding an instruction with rs=$4 -> read_data_1=0xDEADBEEF. The same test with register 0 -> read_data_1 = 0.
- **Load-use.** Decode lw $2,0($1) followed by add $3,$2,$2:
  - stall=1 for one cycle, then the bubble appears in ID/EX (all ctrl 0).
  - add re-decodes; stall=0.
  - add is present in ID/EX on the following edge.
- **Flush.** Assert flush while hazard conditions hold -> stall=0, bubble loaded, no register-file change.
